next_pc_predictor: RTL and testbench
====================================

Name: next_pc_predictor

Overview:
Drives the fetch-stage program counter register. Each cycle it produces the next fetch address and the hold control for the PC register. It predicts branches and jumps with a direct-mapped table of 2-bit saturating counters and a branch target buffer (BTB). It resolves mispredictions reported from EX by redirecting fetch and flushing the front-end pipeline registers.

Parameters:
IDX_W, 4, index width; table depth is 2**IDX_W entries.
RESET_VECTOR, 32'h0000_0000, value of pc_next while reset is asserted.

Ports:
clk  input  1  clock
reset  input  1  reset; synchronous, active-high
pc_cur  input  32  current output of the PC register (address being fetched)
load_use_stall  input  1  hazard unit request to freeze fetch
ex_valid  input  1  EX stage holds a valid instruction
ex_is_branch  input  1  EX instruction is a conditional branch
ex_is_jump  input  1  EX instruction is JAL/JALR
ex_taken  input  1  resolved branch outcome (ignored for jumps, which are always taken)
ex_pc  input  32  PC of the EX instruction
ex_target  input  32  resolved target address
ex_pred_taken  input  1  prediction made for this instruction at fetch, carried down the pipeline
ex_pred_target  input  32  predicted target carried down the pipeline
pc_next  output  32  value loaded into the PC register
pc_hold  output  1  drives the PC register write control; 1 = PC register holds its value, 0 = it loads pc_next
if_pred_taken  output  1  prediction for pc_cur; to be carried with the instruction
if_pred_target  output  32  predicted target for pc_cur
flush  output  1  clears the IF/ID and ID/EX registers
branch_count  output  32  resolved branches/jumps since reset
mispredict_count  output  32  mispredictions since reset

Behaviour:
- Address fields: idx = pc_cur[IDX_W+1:2]; tag = pc_cur[31:IDX_W+2]. EX updates use the same fields taken from ex_pc.
- Storage per entry:
  - bht: 2 bits.
  - btb_valid: 1 bit.
  - btb_tag: 32-IDX_W-2 bits.
  - btb_target: 32 bits.
- Lookup (combinational):
  - hit = btb_valid[idx] and btb_tag[idx] == tag.
  - if_pred_taken = hit and bht[idx][1].
  - if_pred_target = btb_target[idx] when if_pred_taken, else pc_cur + 4.
- Resolution (combinational):
  - resolve = ex_valid and (ex_is_branch or ex_is_jump).
  - actual = ex_is_jump or ex_taken.
  - mispredict = resolve and (actual != ex_pred_taken, or actual and ex_target != ex_pred_target).
- pc_next / pc_hold / flush, in strict priority order:
  1. reset: pc_next = RESET_VECTOR, pc_hold = 0, flush = 0.
  2. mispredict: pc_next = actual ? ex_target : ex_pc + 4; pc_hold = 0; flush = 1. This overrides load_use_stall in the same cycle.
  3. load_use_stall: pc_hold = 1, pc_next = pc_cur, flush = 0.
  4. Otherwise: pc_next = if_pred_target, pc_hold = 0, flush = 0.
- All +4 arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Table update at posedge clk when resolve, and not reset:
  - Branch: bht[ex idx] increments if ex_taken, otherwise decrements; saturates at 0 and 3.
  - Jump: bht set to 3.
  - When actual = 1: btb_valid = 1, btb_tag = ex tag, btb_target = ex_target.
  - Not-taken outcomes never clear a BTB entry.
- Updates happen regardless of load_use_stall.
- Same-cycle update and lookup at the same idx: the lookup uses the pre-edge contents; the new value is visible the next cycle.
- Counters at posedge:
  - branch_count += 1 when resolve.
  - mispredict_count += 1 when mispredict.
  - Both wrap modulo 2^32.
- Reset (single cycle is sufficient):
  - All bht = 2'b01 (weakly not-taken); all btb_valid = 0.
  - Both counters = 0.
  - btb_tag and btb_target are don't-care.
- Reset mid-operation: an update pending in the reset cycle is discarded. The first cycle after reset predicts not-taken for every address.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN = 32.
  - INSTR_BYTES = 4.
  - Constants for the 2-bit counter states: SNT = 0, WNT = 1, WT = 2, ST = 3.
- One sub-module, sat_counter2, provides the pure-function next-state logic for the 2-bit saturating counter.
- Tables stay flat register arrays inside next_pc_predictor.

Test Plan:
1. Reset 2 cycles, pc_cur = 0 -> pc_next = 4, pc_hold = 0, if_pred_taken = 0, both counters 0.
2. load_use_stall = 1, pc_cur = 32'h40 -> pc_hold = 1, pc_next = 32'h40, flush = 0.
3. Resolve a taken branch: ex_pc = 32'h40, ex_target = 32'h100, ex_pred_taken = 0 -> same cycle pc_next = 32'h100, flush = 1, mispredict_count = 1 after the edge. Resolve the same branch taken again, then set pc_cur = 32'h40 -> if_pred_taken = 1, pc_next = 32'h100.
4. Jump mispredict concurrent with load_use_stall = 1: ex_pc = 32'h80, ex_target = 32'h200 -> pc_next = 32'h200, pc_hold = 0, flush = 1. The entry is at bht = 3 afterwards.
5. Aliasing: train 32'h40 taken to ST, then pc_cur = 32'h40 + (4 << IDX_W) = 32'h80 -> same idx, tag mismatch -> if_pred_taken = 0, pc_next = 32'h84.
6. Saturation: 4 consecutive not-taken resolves at 32'h40 after ST -> bht = 0, no underflow. Then reset mid-stream -> all predictions not-taken, counters 0. Also check pc_cur = 32'hFFFF_FFFC -> pc_next = 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared constants for the fetch-stage predictor: datapath width, instruction size, 2-bit counter states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // 2-bit saturating counter states; bit 1 set means "predict taken".
    localparam logic [1:0] SNT = 2'd0;   // strongly not-taken
    localparam logic [1:0] WNT = 2'd1;   // weakly not-taken
    localparam logic [1:0] WT  = 2'd2;   // weakly taken
    localparam logic [1:0] ST  = 2'd3;   // strongly taken

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic of a 2-bit saturating branch counter (pure combinational function).
// Latency: combinational, no state.
// Backpressure: none.
//
// Ports:
//   state  - current counter value
//   taken  - resolved outcome; 1 moves toward ST, 0 toward SNT
//   next   - saturated next counter value
module sat_counter2
    import rv_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = state;
        if (taken) begin
            if (state != ST) next = state + 2'd1;
        end else begin
            if (state != SNT) next = state - 2'd1;
        end
    end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch next-PC generator: BHT + BTB prediction, EX misprediction redirect and front-end flush.
// Latency: pc_next/pc_hold/flush/prediction are combinational; table and counter updates land at the next clk edge.
// Backpressure: load_use_stall holds the PC register unless a misprediction redirect is pending in the same cycle.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   pc_cur, load_use_stall     - current fetch PC and hazard-unit freeze request
//   ex_*                       - resolution info of the instruction in EX (incl. prediction carried from fetch)
//   pc_next, pc_hold           - PC register D input and hold control (1 = hold)
//   if_pred_taken/_target      - prediction for pc_cur, travels down the pipe with the instruction
//   flush                      - clears IF/ID and ID/EX on a misprediction
//   branch_count, mispredict_count - free-running statistics since reset
module next_pc_predictor
    import rv_pkg::*;
#(
    parameter int          IDX_W        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic        load_use_stall,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic [31:0] pc_next,
    output logic        pc_hold,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    output logic        flush,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int          DEPTH = 1 << IDX_W;
    localparam int          TAG_W = XLEN - IDX_W - 2;
    localparam logic [31:0] STEP  = 32'(INSTR_BYTES);

    logic [1:0]       bht        [DEPTH];
    logic [DEPTH-1:0] btb_valid;
    logic [TAG_W-1:0] btb_tag    [DEPTH];
    logic [31:0]      btb_target [DEPTH];

    // Byte-offset bits never address the tables.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{pc_cur[1:0], ex_pc[1:0]};

    logic [IDX_W-1:0] idx, ex_idx;
    logic [TAG_W-1:0] tag, ex_tag;
    assign idx    = pc_cur[IDX_W+1:2];
    assign tag    = pc_cur[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    // Lookup reads the pre-edge table contents, so a same-index update is visible one cycle later.
    logic hit;
    assign hit            = btb_valid[idx] && (btb_tag[idx] == tag);
    assign if_pred_taken  = hit && bht[idx][1];
    assign if_pred_target = if_pred_taken ? btb_target[idx] : pc_cur + STEP;

    logic resolve, actual, mispredict;
    assign resolve    = ex_valid && (ex_is_branch || ex_is_jump);
    assign actual     = ex_is_jump || ex_taken;
    assign mispredict = resolve &&
                        ((actual != ex_pred_taken) || (actual && (ex_target != ex_pred_target)));

    // Redirect wins over the load-use freeze: the stalled instruction is on the wrong path anyway.
    always_comb begin
        pc_next = if_pred_target;
        pc_hold = 1'b0;
        flush   = 1'b0;
        if (reset) begin
            pc_next = RESET_VECTOR;
        end else if (mispredict) begin
            pc_next = actual ? ex_target : ex_pc + STEP;
            flush   = 1'b1;
        end else if (load_use_stall) begin
            pc_next = pc_cur;
            pc_hold = 1'b1;
        end
    end

    logic [1:0] bht_upd;
    sat_counter2 u_sat (
        .state (bht[ex_idx]),
        .taken (ex_taken),
        .next  (bht_upd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) bht[i] <= WNT;
            btb_valid        <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve) begin
                bht[ex_idx]  <= ex_is_jump ? ST : bht_upd;
                branch_count <= branch_count + 32'd1;
                if (actual) btb_valid[ex_idx] <= 1'b1;
            end
            if (mispredict) mispredict_count <= mispredict_count + 32'd1;
        end
    end

    // Tag/target payload needs no reset: it is qualified by btb_valid.
    always_ff @(posedge clk) begin
        if (!reset && resolve && actual) begin
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= ex_target;
        end
    end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed table-driven bench for next_pc_predictor (IDX_W = 4, RESET_VECTOR = 0).
// Each row is one clock cycle: inputs driven after negedge, outputs sampled 2 ns later, before the posedge.
// Counter expectations are accumulated from each row's own stimulus and expected flush.
module tb_next_pc_predictor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_cur = '0;
    logic        load_use_stall = 1'b0;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0, ex_taken = 1'b0;
    logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] pc_next, if_pred_target, branch_count, mispredict_count;
    logic        pc_hold, if_pred_taken, flush;

    always #5 clk = ~clk;

    next_pc_predictor #(.IDX_W(4), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .pc_cur(pc_cur), .load_use_stall(load_use_stall),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .pc_next(pc_next), .pc_hold(pc_hold), .if_pred_taken(if_pred_taken),
        .if_pred_target(if_pred_target), .flush(flush),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        stall, ev, br, jp, tk;
        logic [31:0] epc, etgt;
        logic        ept;
        logic [31:0] eptg;
        logic [31:0] nxt;
        logic        hold, fl, pt, chk_pt;
    } vec_t;

    vec_t vecs[$];
    int applied = 0;
    int miscompares = 0;
    logic [31:0] exp_bc = '0, exp_mc = '0;
    bit cnt_known = 1'b0;

    function automatic vec_t row(input logic rst, input logic [31:0] pc, input logic stall,
                                 input logic ev, input logic br, input logic jp, input logic tk,
                                 input logic [31:0] epc, input logic [31:0] etgt,
                                 input logic ept, input logic [31:0] eptg,
                                 input logic [31:0] nxt, input logic hold, input logic fl,
                                 input logic pt, input logic chk_pt);
        vec_t v;
        v.rst = rst; v.pc = pc; v.stall = stall; v.ev = ev; v.br = br; v.jp = jp; v.tk = tk;
        v.epc = epc; v.etgt = etgt; v.ept = ept; v.eptg = eptg;
        v.nxt = nxt; v.hold = hold; v.fl = fl; v.pt = pt; v.chk_pt = chk_pt;
        return v;
    endfunction

    // Idle cycle: no EX resolution, no stall.
    function automatic vec_t idle(input logic [31:0] pc, input logic [31:0] nxt, input logic pt);
        return row(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                   nxt, 1'b0, 1'b0, pt, 1'b1);
    endfunction

    // Conditional branch resolving in EX while fetching pc.
    function automatic vec_t br_row(input logic [31:0] pc, input logic tk, input logic [31:0] epc,
                                    input logic [31:0] etgt, input logic ept, input logic [31:0] eptg,
                                    input logic [31:0] nxt, input logic fl, input logic pt);
        return row(1'b0, pc, 1'b0, 1'b1, 1'b1, 1'b0, tk, epc, etgt, ept, eptg,
                   nxt, 1'b0, fl, pt, 1'b1);
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset = v.rst; pc_cur = v.pc; load_use_stall = v.stall;
        ex_valid = v.ev; ex_is_branch = v.br; ex_is_jump = v.jp; ex_taken = v.tk;
        ex_pc = v.epc; ex_target = v.etgt; ex_pred_taken = v.ept; ex_pred_target = v.eptg;
        #2;
        check32({tag, " pc_next"}, pc_next, v.nxt);
        check32({tag, " pc_hold"}, {31'b0, pc_hold}, {31'b0, v.hold});
        check32({tag, " flush"}, {31'b0, flush}, {31'b0, v.fl});
        if (v.chk_pt) check32({tag, " if_pred_taken"}, {31'b0, if_pred_taken}, {31'b0, v.pt});
        if (cnt_known) begin
            check32({tag, " branch_count"}, branch_count, exp_bc);
            check32({tag, " mispredict_count"}, mispredict_count, exp_mc);
        end
        // Expected counters after the coming posedge.
        if (v.rst) begin
            exp_bc = '0; exp_mc = '0; cnt_known = 1'b1;
        end else begin
            if (v.ev && (v.br || v.jp)) exp_bc = exp_bc + 32'd1;
            if (v.fl) exp_mc = exp_mc + 32'd1;
        end
    endtask

    initial begin
        // Reset, stall, first training.
        vecs.push_back(row(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
        vecs.push_back(row(1, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
        vecs.push_back(idle(32'h0, 32'h4, 0));
        vecs.push_back(row(0, 32'h40, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1, 0, 0, 1));
        vecs.push_back(br_row(32'h100, 1, 32'h40, 32'h100, 0, 32'h44, 32'h100, 1, 0));
        vecs.push_back(br_row(32'h104, 1, 32'h40, 32'h100, 1, 32'h100, 32'h108, 0, 0));
        vecs.push_back(idle(32'h40, 32'h100, 1));
        // Jump mispredict concurrent with stall; overwrites idx 0 with tag of 0x80.
        vecs.push_back(row(0, 32'h44, 1, 1, 0, 1, 0, 32'h80, 32'h200, 0, 32'h84,
                           32'h200, 0, 1, 0, 1));
        vecs.push_back(idle(32'h80, 32'h200, 1));
        vecs.push_back(idle(32'h40, 32'h44, 0));
        // Retrain 0x40, then 0x80 aliases to the same index with a different tag.
        vecs.push_back(br_row(32'h200, 1, 32'h40, 32'h100, 0, 32'h44, 32'h100, 1, 0));
        vecs.push_back(idle(32'h80, 32'h84, 0));
        vecs.push_back(idle(32'h40, 32'h100, 1));
        // Right direction, wrong target still mispredicts.
        vecs.push_back(br_row(32'h104, 1, 32'h40, 32'h100, 1, 32'h180, 32'h100, 1, 0));
        // ex_valid low: branch fields ignored, no redirect, no count.
        vecs.push_back(row(0, 32'h40, 0, 0, 1, 0, 1, 32'h40, 32'h999, 0, 32'h0,
                           32'h100, 0, 0, 1, 1));
        // Not-taken run down from ST: 3->2->1->0->0; lookup sees pre-edge value.
        vecs.push_back(br_row(32'h40, 0, 32'h40, 32'h100, 1, 32'h100, 32'h44, 1, 1));
        vecs.push_back(br_row(32'h40, 0, 32'h40, 32'h100, 1, 32'h100, 32'h44, 1, 1));
        vecs.push_back(br_row(32'h40, 0, 32'h40, 32'h100, 0, 32'h44, 32'h44, 0, 0));
        vecs.push_back(br_row(32'h40, 0, 32'h40, 32'h100, 0, 32'h44, 32'h44, 0, 0));
        vecs.push_back(idle(32'h40, 32'h44, 0));
        // One taken from SNT only reaches WNT.
        vecs.push_back(br_row(32'h40, 1, 32'h40, 32'h100, 0, 32'h44, 32'h100, 1, 0));
        vecs.push_back(idle(32'h40, 32'h44, 0));
        vecs.push_back(idle(32'hFFFF_FFFC, 32'h0, 0));
        vecs.push_back(br_row(32'h40, 1, 32'h40, 32'h100, 0, 32'h44, 32'h100, 1, 0));
        // Mid-stream reset with a pending taken update that must be discarded.
        vecs.push_back(row(1, 32'h40, 1, 1, 1, 0, 1, 32'h40, 32'h100, 0, 32'h44,
                           32'h0, 0, 0, 0, 0));
        vecs.push_back(idle(32'h40, 32'h44, 0));
        vecs.push_back(idle(32'h80, 32'h84, 0));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("row%0d", i));

        // Same-cycle update and lookup at idx 15: old contents now, new contents next cycle.
        apply(row(0, 32'h3C, 0, 1, 0, 1, 0, 32'h3C, 32'h500, 0, 32'h40,
                  32'h500, 0, 1, 0, 1), "seq_same_idx");
        check32("seq_same_idx if_pred_target", if_pred_target, 32'h40);
        apply(idle(32'h3C, 32'h500, 1), "seq_next_cycle");
        check32("seq_next_cycle if_pred_target", if_pred_target, 32'h500);
        // Same idx 15, different tag, and +4 wraps to zero.
        apply(idle(32'hFFFF_FFFC, 32'h0, 0), "seq_wrap");
        check32("seq_wrap if_pred_target", if_pred_target, 32'h0);
        // Taken branch predicted correctly by the freshly written entry keeps fetch on target.
        apply(row(0, 32'h3C, 0, 1, 1, 0, 1, 32'h3C, 32'h500, 1, 32'h500,
                  32'h500, 0, 0, 1, 1), "seq_correct");
        apply(idle(32'h500, 32'h504, 0), "seq_final");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
